// File: rtl/maple_frame_rx_pkg.sv
// Maple frame receiver shared definitions.
// FSM encodings, header byte indices and counter width.
package maple_frame_rx_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HEADER   = 3'd1;
    localparam logic [2:0] ST_PAYLOAD  = 3'd2;
    localparam logic [2:0] ST_CHECKSUM = 3'd3;
    localparam logic [2:0] ST_EXTRA    = 3'd4;

    localparam logic [1:0] HDR_LEN = 2'd0;
    localparam logic [1:0] HDR_SRC = 2'd1;
    localparam logic [1:0] HDR_DST = 2'd2;
    localparam logic [1:0] HDR_CMD = 2'd3;

    localparam int MAPLE_CNT_W = 11;

endpackage

// File: rtl/maple_edge_det.sv
// Rising-edge detector on a registered copy of a level.
// A level already high when reset releases is not reported as an edge.
module maple_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic edge_o
);

    logic d_q;
    logic armed_q;

    // Track previous level; arm one cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            d_q     <= d;
            armed_q <= 1'b1;
        end
    end

    assign edge_o = armed_q & d & ~d_q;

endmodule

// File: rtl/maple_frame_rx.sv
// Inline Maple frame parser: 1-cycle byte pass-through plus
// header capture, payload length and XOR checksum checking.
module maple_frame_rx
    import maple_frame_rx_pkg::*;
#(
    parameter int MAX_WORDS = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       start_det,
    input  logic       end_det,
    input  logic [7:0] in_data,
    input  logic       in_strobe,
    output logic [7:0] out_data,
    output logic       out_strobe,
    output logic [7:0] hdr_len,
    output logic [7:0] hdr_src,
    output logic [7:0] hdr_dst,
    output logic [7:0] hdr_cmd,
    output logic       busy,
    output logic       done,
    output logic       frame_ok,
    output logic       len_err,
    output logic       csum_err
);

    logic start_edge;
    logic end_edge;

    maple_edge_det u_start_edge (
        .clk   (clk),
        .rst_n (rst),
        .d     (start_det),
        .edge_o(start_edge)
    );

    maple_edge_det u_end_edge (
        .clk   (clk),
        .rst_n (rst),
        .d     (end_det),
        .edge_o(end_edge)
    );

    logic [2:0]             state_q,    state_d;
    logic [MAPLE_CNT_W-1:0] cnt_q,      cnt_d;
    logic [7:0]             xor_q,      xor_d;
    logic [7:0]             hdr_len_q,  hdr_len_d;
    logic [7:0]             hdr_src_q,  hdr_src_d;
    logic [7:0]             hdr_dst_q,  hdr_dst_d;
    logic [7:0]             hdr_cmd_q,  hdr_cmd_d;
    logic                   done_q,     done_d;
    logic                   ok_q,       ok_d;
    logic                   len_err_q,  len_err_d;
    logic                   csum_err_q, csum_err_d;
    logic [7:0]             out_data_q;
    logic                   out_strobe_q;

    logic [MAPLE_CNT_W-1:0] last_pl_idx;
    logic                   over_len;

    assign last_pl_idx = {1'b0, hdr_len_q, 2'b11};
    assign over_len    = {24'd0, in_data} > 32'(MAX_WORDS);

    // Parser next-state: byte handling first, then end edge
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        xor_d      = xor_q;
        hdr_len_d  = hdr_len_q;
        hdr_src_d  = hdr_src_q;
        hdr_dst_d  = hdr_dst_q;
        hdr_cmd_d  = hdr_cmd_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        len_err_d  = len_err_q;
        csum_err_d = csum_err_q;
        if (clear || start_edge) begin
            state_d    = clear ? ST_IDLE : ST_HEADER;
            cnt_d      = '0;
            xor_d      = '0;
            hdr_len_d  = '0;
            hdr_src_d  = '0;
            hdr_dst_d  = '0;
            hdr_cmd_d  = '0;
            ok_d       = 1'b0;
            len_err_d  = 1'b0;
            csum_err_d = 1'b0;
        end else begin
            if (in_strobe) begin
                case (state_q)
                    ST_HEADER: begin
                        xor_d = xor_q ^ in_data;
                        cnt_d = cnt_q + 1'b1;
                        case (cnt_q[1:0])
                            HDR_LEN: begin
                                hdr_len_d = in_data;
                                if (over_len) len_err_d = 1'b1;
                            end
                            HDR_SRC: hdr_src_d = in_data;
                            HDR_DST: hdr_dst_d = in_data;
                            default: hdr_cmd_d = in_data;
                        endcase
                        if (cnt_q[1:0] == HDR_CMD)
                            state_d = (hdr_len_q == 8'd0) ? ST_CHECKSUM
                                                          : ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        xor_d = xor_q ^ in_data;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == last_pl_idx) state_d = ST_CHECKSUM;
                    end
                    ST_CHECKSUM: begin
                        cnt_d = cnt_q + 1'b1;
                        if (in_data != xor_q) csum_err_d = 1'b1;
                        state_d = ST_EXTRA;
                    end
                    ST_EXTRA: len_err_d = 1'b1;
                    default: ;
                endcase
            end
            if (end_edge && state_q != ST_IDLE) begin
                if (state_d != ST_EXTRA) len_err_d = 1'b1;
                done_d  = 1'b1;
                ok_d    = !len_err_d && !csum_err_d;
                state_d = ST_IDLE;
            end
        end
    end

    // Parser state and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            xor_q      <= '0;
            hdr_len_q  <= '0;
            hdr_src_q  <= '0;
            hdr_dst_q  <= '0;
            hdr_cmd_q  <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            len_err_q  <= 1'b0;
            csum_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            xor_q      <= xor_d;
            hdr_len_q  <= hdr_len_d;
            hdr_src_q  <= hdr_src_d;
            hdr_dst_q  <= hdr_dst_d;
            hdr_cmd_q  <= hdr_cmd_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            len_err_q  <= len_err_d;
            csum_err_q <= csum_err_d;
        end
    end

    // One-cycle byte pass-through toward the read FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
        end else begin
            out_data_q   <= in_data;
            out_strobe_q <= in_strobe;
        end
    end

    assign out_data   = out_data_q;
    assign out_strobe = out_strobe_q;
    assign hdr_len    = hdr_len_q;
    assign hdr_src    = hdr_src_q;
    assign hdr_dst    = hdr_dst_q;
    assign hdr_cmd    = hdr_cmd_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign frame_ok   = ok_q;
    assign len_err    = len_err_q;
    assign csum_err   = csum_err_q;

endmodule

// File: tb/tb_maple_frame_rx.sv
// Bench for maple_frame_rx: directed frames, scoreboard
// queues for pass-through bytes and per-frame status.
module tb_maple_frame_rx;

    typedef struct {
        logic [7:0] len;
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] cmd;
        logic       ok;
        logic       le;
        logic       ce;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       start_det = 1'b0;
    logic       end_det = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_strobe = 1'b0;
    logic [7:0] out_data;
    logic       out_strobe;
    logic [7:0] hdr_len, hdr_src, hdr_dst, hdr_cmd;
    logic       busy, done, frame_ok, len_err, csum_err;

    int n_checks = 0;
    int n_fail = 0;

    exp_t       exp_q[$];
    logic [7:0] pass_q[$];

    logic [7:0] f1[9] = '{8'h01, 8'h00, 8'h20, 8'h01, 8'h12,
                          8'h34, 8'h56, 8'h78, 8'h28};

    maple_frame_rx dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .start_det (start_det),
        .end_det   (end_det),
        .in_data   (in_data),
        .in_strobe (in_strobe),
        .out_data  (out_data),
        .out_strobe(out_strobe),
        .hdr_len   (hdr_len),
        .hdr_src   (hdr_src),
        .hdr_dst   (hdr_dst),
        .hdr_cmd   (hdr_cmd),
        .busy      (busy),
        .done      (done),
        .frame_ok  (frame_ok),
        .len_err   (len_err),
        .csum_err  (csum_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare pass-through bytes and frame results
    always @(negedge clk) begin
        if (rst) begin
            if (out_strobe) begin
                if (pass_q.size() == 0)
                    check("unexpected_strobe", 1, 0);
                else
                    check("pass_data", {56'd0, out_data}, {56'd0, pass_q.pop_front()});
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("hdr", {32'd0, hdr_len, hdr_src, hdr_dst, hdr_cmd},
                          {32'd0, e.len, e.src, e.dst, e.cmd});
                    check("frame_ok", {63'd0, frame_ok}, {63'd0, e.ok});
                    check("len_err", {63'd0, len_err}, {63'd0, e.le});
                    check("csum_err", {63'd0, csum_err}, {63'd0, e.ce});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        in_data = b;
        in_strobe = 1'b1;
        pass_q.push_back(b);
        @(posedge clk); #1;
        in_strobe = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        start_det = 1'b1;
        @(posedge clk); #1;
        start_det = 1'b0;
    endtask

    task automatic end_pulse();
        @(posedge clk); #1;
        end_det = 1'b1;
        @(posedge clk); #1;
        end_det = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] l, input logic [7:0] s,
                            input logic [7:0] d, input logic [7:0] c,
                            input logic ok, input logic le, input logic ce);
        exp_t e;
        e.len = l; e.src = s; e.dst = d; e.cmd = c;
        e.ok = ok; e.le = le; e.ce = ce;
        exp_q.push_back(e);
    endtask

    initial begin
        // level high across reset release must not start a frame
        start_det = 1'b1;
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        check("reset_outs", {50'd0, out_data, out_strobe, hdr_len, hdr_src,
              hdr_dst, hdr_cmd, busy, done, frame_ok, len_err, csum_err}, 64'd0);
        idle(3);
        check("no_edge_at_release", {63'd0, busy}, 64'd0);
        start_det = 1'b0;
        idle(2);

        // byte outside a frame: passed, not parsed
        send(8'h5A);
        idle(2);
        check("idle_byte_no_parse", {56'd0, hdr_len}, 64'd0);

        // 1: good frame
        start_pulse();
        check("busy_after_start", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 9; i++) send(f1[i]);
        push_exp(8'h01, 8'h00, 8'h20, 8'h01, 1, 0, 0);
        end_pulse();
        idle(3);
        check("busy_after_end", {63'd0, busy}, 64'd0);
        check("status_hold", {63'd0, frame_ok}, 64'd1);

        // clear wipes status and header
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear", {46'd0, frame_ok, len_err, csum_err, hdr_len, hdr_dst}, 64'd0);

        // 2: bad checksum
        start_pulse();
        for (int i = 0; i < 8; i++) send(f1[i]);
        send(8'h29);
        push_exp(8'h01, 8'h00, 8'h20, 8'h01, 0, 0, 1);
        end_pulse();
        idle(3);

        // 3: short frame
        start_pulse();
        for (int i = 0; i < 6; i++) send(f1[i]);
        push_exp(8'h01, 8'h00, 8'h20, 8'h01, 0, 1, 0);
        end_pulse();
        idle(3);

        // 4: long frame
        start_pulse();
        for (int i = 0; i < 9; i++) send(f1[i]);
        send(8'hAA);
        push_exp(8'h01, 8'h00, 8'h20, 8'h01, 0, 1, 0);
        end_pulse();
        idle(3);

        // 5: len=0, checksum byte with the end edge
        start_pulse();
        send(8'h00);
        send(8'h00);
        send(8'h20);
        send(8'h03);
        push_exp(8'h00, 8'h00, 8'h20, 8'h03, 1, 0, 0);
        @(posedge clk); #1;
        in_data = 8'h23;
        in_strobe = 1'b1;
        end_det = 1'b1;
        pass_q.push_back(8'h23);
        @(posedge clk); #1;
        in_strobe = 1'b0;
        end_det = 1'b0;
        idle(3);

        // 6: restart mid-frame
        start_pulse();
        for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i));
        start_pulse();
        for (int i = 0; i < 9; i++) send(f1[i]);
        push_exp(8'h01, 8'h00, 8'h20, 8'h01, 1, 0, 0);
        end_pulse();
        idle(3);

        // async reset mid-frame clears everything at once
        start_pulse();
        send(8'h01);
        send(8'h07);
        idle(2);
        check("busy_mid_frame", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_frame", {50'd0, out_data, out_strobe, hdr_len, hdr_src,
              hdr_dst, hdr_cmd, busy, done, frame_ok, len_err, csum_err}, 64'd0);
        idle(2);
        rst = 1'b1;
        idle(4);

        check("pending_frames", 64'(exp_q.size()), 64'd0);
        check("pending_bytes", 64'(pass_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
